// File: rtl/gnrl_bitstr_seq_if.sv
// Bundles the sequencer's SoC control, FIFO read side and status/output bus.
// The master is the SoC/FIFO environment and the slave is the sequencer.
interface gnrl_bitstr_seq_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int WCNT_WIDTH = 16
);
    localparam int W = BUS_WIDTH + CNT_WIDTH + 1;

    logic                  START;
    logic                  ABORT;
    logic [BUS_WIDTH-1:0]  IDLE_VAL;
    logic [W-1:0]          fifo_data;
    logic                  fifo_empty;
    logic                  fifo_rdreq;
    logic [BUS_WIDTH-1:0]  bitstr_out;
    logic                  BUSY;
    logic                  DONE;
    logic                  UNDERFLOW;
    logic [WCNT_WIDTH-1:0] WORD_CNT;

    modport master (
        output START, ABORT, IDLE_VAL, fifo_data, fifo_empty,
        input  fifo_rdreq, bitstr_out, BUSY, DONE, UNDERFLOW, WORD_CNT
    );

    modport slave (
        input  START, ABORT, IDLE_VAL, fifo_data, fifo_empty,
        output fifo_rdreq, bitstr_out, BUSY, DONE, UNDERFLOW, WORD_CNT
    );
endinterface

// File: rtl/gnrl_bitstr_seq.sv
// Bitstream sequencer: pulls {end, hold, pattern} words from a show-ahead FIFO
// and drives each pattern for hold+1 cycles, stopping on the end flag and
// driving IDLE_VAL whenever no word is active. Reports busy/done/underflow
// and the number of words consumed since the last start.
module gnrl_bitstr_seq #(
    parameter int BUS_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int WCNT_WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    gnrl_bitstr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, DONE_ST, ERR} state_e;

    state_e                state_q, state_d;
    logic                  start_q, start_d;
    logic [BUS_WIDTH-1:0]  out_q, out_d;
    logic [CNT_WIDTH-1:0]  hold_cnt_q, hold_cnt_d;
    logic                  end_q, end_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  underflow_q, underflow_d;
    logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;

    logic                  start_edge;
    logic                  load;
    logic [BUS_WIDTH-1:0]  head_pat;
    logic [CNT_WIDTH-1:0]  head_hold;
    logic                  head_end;

    assign head_pat  = bus.fifo_data[BUS_WIDTH-1:0];
    assign head_hold = bus.fifo_data[BUS_WIDTH+CNT_WIDTH-1:BUS_WIDTH];
    assign head_end  = bus.fifo_data[BUS_WIDTH+CNT_WIDTH];

    // Next-state and output logic; ABORT overrides every state, a load is
    // merged in at the end so IDLE and HOLD share the same word-fetch path.
    always_comb begin
        state_d     = state_q;
        start_d     = bus.START;
        out_d       = out_q;
        hold_cnt_d  = hold_cnt_q;
        end_d       = end_q;
        done_d      = done_q;
        underflow_d = underflow_q;
        wcnt_d      = wcnt_q;
        load        = 1'b0;
        start_edge  = bus.START & ~start_q;

        if (bus.ABORT) begin
            state_d = IDLE;
            out_d   = bus.IDLE_VAL;
        end else begin
            case (state_q)
                IDLE: begin
                    out_d = bus.IDLE_VAL;
                    if (start_edge) begin
                        done_d      = 1'b0;
                        underflow_d = 1'b0;
                        wcnt_d      = '0;
                        if (!bus.fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            underflow_d = 1'b1;
                            state_d     = ERR;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - CNT_WIDTH'(1);
                    end else if (end_q) begin
                        out_d   = bus.IDLE_VAL;
                        done_d  = 1'b1;
                        state_d = DONE_ST;
                    end else if (!bus.fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        out_d       = bus.IDLE_VAL;
                        underflow_d = 1'b1;
                        state_d     = ERR;
                    end
                end
                DONE_ST, ERR: begin
                    // Wait for START to drop so the next rising edge re-arms.
                    out_d = bus.IDLE_VAL;
                    if (!bus.START) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = bus.IDLE_VAL;
                end
            endcase
        end

        // The counter add sees the cleared value when a start load coincides
        // with the clear, so the first word of a sequence counts as 1.
        if (load) begin
            out_d      = head_pat;
            hold_cnt_d = head_hold;
            end_d      = head_end;
            wcnt_d     = wcnt_d + WCNT_WIDTH'(1);
            state_d    = HOLD;
        end

        busy_d = (state_d == HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            out_q       <= '0;
            hold_cnt_q  <= '0;
            end_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            out_q       <= out_d;
            hold_cnt_q  <= hold_cnt_d;
            end_q       <= end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign bus.fifo_rdreq = load & ~RST;
    assign bus.bitstr_out = out_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.UNDERFLOW  = underflow_q;
    assign bus.WORD_CNT   = wcnt_q;
endmodule
